fir_mac_seq: RTL and testbench

- Downstream consumer of the FIR tap-delay line. Takes an N-tap snapshot of signed 16-bit samples and runs a time-multiplexed multiply-accumulate against a programmable coefficient bank, one tap per cycle.
- Rounds and saturates the sum to Q15, then presents one output sample per accepted snapshot on a valid/ready interface.

---
 rtl/fir_pkg.sv | 8 +
 rtl/fir_mac_seq_if.sv | 10 +
 rtl/fir_round_sat.sv | 17 +
 rtl/fir_mac_seq.sv | 75 +++++++
 tb/tb_fir_mac_seq.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the sequential FIR MAC.
package fir_pkg;
    typedef enum logic [1:0] {IDLE, MAC, ROUND, HOLD} state_t;
    localparam int SAMPLE_W = 16;
    localparam int COEF_W = 16;
    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;
endpackage

// File: rtl/fir_mac_seq_if.sv
// fir_mac_seq_if: tap snapshot in and filtered sample out, each with a valid/ready pair.
interface fir_mac_seq_if import fir_pkg::*; #(parameter int N = 8);
    logic taps_valid;
    logic signed [SAMPLE_W-1:0] taps [N];
    logic out_valid;
    logic out_ready;
    logic signed [SAMPLE_W-1:0] data_out;
    modport master (output taps_valid, taps, out_ready, input out_valid, data_out);
    modport slave (input taps_valid, taps, out_ready, output out_valid, data_out);
endinterface

// File: rtl/fir_round_sat.sv
// fir_round_sat: round-half-up, arithmetic shift and saturate an accumulator to Q15.
module fir_round_sat import fir_pkg::*; #(
    parameter int ACC_W = 40,
    parameter int OUT_SHIFT = 15
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [SAMPLE_W-1:0] y
);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (OUT_SHIFT - 1);
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(SAT_MIN);
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] r;
    assign sum = acc + HALF;
    assign r = sum >>> OUT_SHIFT;
    assign y = r > HI ? SAT_MAX : r < LO ? SAT_MIN : r[SAMPLE_W-1:0];
endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: one-tap-per-cycle MAC over an N-tap snapshot and a programmable
// coefficient bank, with Q15 round/saturate and a valid/ready output.
module fir_mac_seq import fir_pkg::*; #(
    parameter int N = 8,
    parameter int ACC_W = 40,
    parameter int OUT_SHIFT = 15
) (
    input  logic clk,
    input  logic rst,
    fir_mac_seq_if.slave bus,
    input  logic coef_we,
    input  logic [$clog2(N)-1:0] coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic busy,
    output logic drop_err,
    input  logic drop_clr
);
    localparam int AW = $clog2(N);
    localparam int PW = SAMPLE_W + COEF_W;
    state_t state, state_n;
    logic signed [SAMPLE_W-1:0] snap [N];
    logic signed [COEF_W-1:0] coef [N];
    logic signed [ACC_W-1:0] acc;
    logic [AW-1:0] idx;
    logic signed [PW-1:0] prod;
    logic signed [SAMPLE_W-1:0] rounded;
    logic last, accept, hs, drop;
    assign busy = state != IDLE;
    assign last = idx == AW'(N - 1);
    assign accept = state == IDLE && bus.taps_valid;
    assign hs = state == HOLD && bus.out_valid && bus.out_ready;
    assign drop = busy && (bus.taps_valid || coef_we);
    assign prod = PW'(snap[idx]) * PW'(coef[idx]);
    fir_round_sat #(.ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)) u_round_sat (
        .acc(acc),
        .y(rounded)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.taps_valid ? MAC : IDLE;
            MAC:     state_n = last ? ROUND : MAC;
            ROUND:   state_n = HOLD;
            HOLD:    state_n = hs ? IDLE : HOLD;
            default: state_n = IDLE;
        endcase
    end
    // data_out is registered leaving ROUND; out_valid follows one cycle later in HOLD
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            acc <= '0;
            idx <= '0;
            bus.out_valid <= 1'b0;
            bus.data_out <= '0;
            drop_err <= 1'b0;
        end else begin
            state <= state_n;
            acc <= accept ? '0 : state == MAC ? acc + ACC_W'(prod) : acc;
            idx <= accept || (state == MAC && last) ? '0 : state == MAC ? idx + AW'(1) : idx;
            bus.data_out <= state == ROUND ? rounded : bus.data_out;
            bus.out_valid <= state == HOLD && !hs;
            drop_err <= drop || (drop_err && !drop_clr);
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                snap[i] <= '0;
                coef[i] <= '0;
            end
        end else begin
            if (accept) snap <= bus.taps;
            if (coef_we && !busy && int'(coef_addr) < N) coef[coef_addr] <= coef_wdata;
        end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: vector table, hand-written corner sequences and a random run
// checked against a sum-of-products reference for fir_mac_seq.
module tb_fir_mac_seq;
    import fir_pkg::*;
    localparam int N = 8;
    typedef logic signed [15:0] vec_t [N];
    typedef struct {
        logic signed [15:0] t0;
        logic signed [15:0] tr;
        logic signed [15:0] c0;
        logic signed [15:0] cr;
        logic signed [15:0] exp;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic coef_we = 1'b0;
    logic [2:0] coef_addr = '0;
    logic signed [15:0] coef_wdata = '0;
    logic drop_clr = 1'b0;
    logic busy, drop_err;
    int passed = 0;
    int total = 0;
    vec_t mcoef;

    fir_mac_seq_if #(.N(N)) bus();
    fir_mac_seq #(.N(N), .ACC_W(40), .OUT_SHIFT(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .coef_we(coef_we),
        .coef_addr(coef_addr),
        .coef_wdata(coef_wdata),
        .busy(busy),
        .drop_err(drop_err),
        .drop_clr(drop_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // reference: exact sum of products, round half up, clamp to 16-bit signed
    function automatic logic signed [15:0] ref_out(input vec_t t, input vec_t c);
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(t[i]) * longint'(c[i]);
        s = (s + 64'sd16384) >>> 15;
        return s > 32767 ? 16'sh7FFF : s < -32768 ? 16'sh8000 : 16'(s);
    endfunction

    task automatic wr_coef(input int a, input logic signed [15:0] d);
        coef_addr = 3'(a);
        coef_wdata = d;
        coef_we = 1'b1;
        tick;
        coef_we = 1'b0;
        mcoef[a] = d;
    endtask

    task automatic load_coefs(input vec_t c);
        for (int i = 0; i < N; i++) wr_coef(i, c[i]);
    endtask

    task automatic run(input vec_t t, input logic signed [15:0] exp, input string name, input int ready_delay);
        int lat = 0;
        int gaps = 0;
        bus.taps = t;
        bus.taps_valid = 1'b1;
        tick;
        bus.taps_valid = 1'b0;
        check({name, " busy"}, busy, 1);
        while (!bus.out_valid && lat < 40) begin
            tick;
            lat++;
            if (!busy) gaps++;
        end
        check({name, " latency"}, lat, 10);
        check({name, " data"}, bus.data_out, exp);
        repeat (ready_delay) begin
            tick;
            if (!busy) gaps++;
            check({name, " hold"}, bus.data_out, exp);
        end
        check({name, " busy gaps"}, gaps, 0);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        check({name, " idle after handshake"}, {bus.out_valid, busy}, 0);
    endtask

    initial begin
        row_t tab [7];
        vec_t t, c;
        int seen;
        for (int i = 0; i < N; i++) mcoef[i] = '0;
        bus.taps_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.taps = '{default: 16'sh0};
        repeat (2) tick;
        check("reset busy", busy, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset data_out", bus.data_out, 0);
        check("reset drop_err", drop_err, 0);
        rst = 1'b0;
        tick;

        t = '{default: 16'sh1234};
        run(t, 16'sh0000, "reset coefs", 0);

        tab = '{
            '{16'sh4000, 16'sh7777, 16'sh7FFF, 16'sh0000, 16'sh4000},
            '{16'sh4000, 16'sh7777, 16'sh0001, 16'sh0000, 16'sh0001},
            '{16'sh3FFF, 16'sh7777, 16'sh0001, 16'sh0000, 16'sh0000},
            '{16'shC000, 16'sh7777, 16'sh0001, 16'sh0000, 16'sh0000},
            '{16'shBFFF, 16'sh7777, 16'sh0001, 16'sh0000, 16'shFFFF},
            '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF},
            '{16'sh8000, 16'sh8000, 16'sh7FFF, 16'sh7FFF, 16'sh8000}
        };
        for (int r = 0; r < 7; r++) begin
            c = '{default: tab[r].cr};
            c[0] = tab[r].c0;
            t = '{default: tab[r].tr};
            t[0] = tab[r].t0;
            load_coefs(c);
            run(t, tab[r].exp, $sformatf("row%0d", r), 0);
        end

        // backpressure with rejected snapshot and coefficient write while held
        c = '{default: 16'sh0000};
        c[0] = 16'sh7FFF;
        load_coefs(c);
        t = '{default: 16'sh0000};
        t[0] = 16'sh4000;
        bus.taps = t;
        bus.taps_valid = 1'b1;
        tick;
        bus.taps_valid = 1'b0;
        seen = 0;
        while (!bus.out_valid && seen < 40) begin
            tick;
            seen++;
        end
        check("bp latency", seen, 10);
        for (int k = 0; k < 5; k++) begin
            bus.taps = '{default: 16'sh7FFF};
            bus.taps_valid = k == 1;
            drop_clr = k == 1 || k == 2;
            coef_we = k == 3;
            coef_addr = 3'd0;
            coef_wdata = 16'sh1234;
            tick;
            check($sformatf("bp data k%0d", k), bus.data_out, 16'sh4000);
            check($sformatf("bp valid k%0d", k), bus.out_valid, 1);
            check($sformatf("bp drop_err k%0d", k), drop_err, (k == 1 || k >= 3) ? 1 : 0);
        end
        bus.taps_valid = 1'b0;
        drop_clr = 1'b0;
        coef_we = 1'b0;
        bus.out_ready = 1'b1;
        bus.taps_valid = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        bus.taps_valid = 1'b0;
        check("bp handshake out_valid", bus.out_valid, 0);
        check("bp no accept on handshake", busy, 0);
        run(t, 16'sh4000, "coef kept", 0);
        check("drop_err sticky", drop_err, 1);
        drop_clr = 1'b1;
        tick;
        drop_clr = 1'b0;
        check("drop_clr clears", drop_err, 0);

        // reset four edges after accept
        c = '{default: 16'sh7FFF};
        load_coefs(c);
        bus.taps = '{default: 16'sh1000};
        bus.taps_valid = 1'b1;
        tick;
        bus.taps_valid = 1'b0;
        repeat (4) tick;
        rst = 1'b1;
        #1;
        check("mid reset busy", busy, 0);
        check("mid reset out_valid", bus.out_valid, 0);
        check("mid reset data_out", bus.data_out, 0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < N; i++) mcoef[i] = '0;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (15) begin
            tick;
            if (bus.out_valid || busy) seen++;
        end
        bus.out_ready = 1'b0;
        check("no output after reset", seen, 0);
        t = '{default: 16'sh7FFF};
        run(t, ref_out(t, mcoef), "coefs cleared", 0);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < N; i++) begin
                c[i] = n < 10 ? 16'($urandom_range(0, 63)) - 16'sd32 : 16'($urandom);
                t[i] = 16'($urandom);
            end
            load_coefs(c);
            run(t, ref_out(t, mcoef), $sformatf("rand%0d", n), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
